// File: rtl/mult_div_unit_pkg.sv
// Shared op codes and FSM state type for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [1:0] MDU_OP_MULTU = 2'b00;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b01;
  localparam logic [1:0] MDU_OP_MULT  = 2'b10;
  localparam logic [1:0] MDU_OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MDU_IDLE   = 2'd0,
    MDU_RUN    = 2'd1,
    MDU_FINISH = 2'd2
  } mdu_state_t;

  function automatic logic mdu_is_div(input logic [1:0] op);
    return (op == MDU_OP_DIVU) || (op == MDU_OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// One combinational iteration: shift-add multiply or restoring divide step.
module mdu_step
  import mult_div_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2*N:0] acc,
  input  logic [N-1:0] operand,
  input  logic [1:0]   op,
  output logic [2*N:0] acc_next
);

  logic [N:0]   sum;
  logic [2*N:0] shifted;
  logic [N+1:0] trial;

  // Accumulator layout: acc[2N:N] is P_hi (mul, top bit 0) or remainder R (div);
  // acc[N-1:0] is P_lo or quotient Q.
  always_comb begin
    sum      = '0;
    shifted  = '0;
    trial    = '0;
    acc_next = acc;
    if (mdu_is_div(op)) begin
      shifted = {acc[2*N-1:0], 1'b0};
      trial   = {1'b0, shifted[2*N:N]} - {2'b00, operand};
      if (!trial[N+1])
        acc_next = {trial[N:0], shifted[N-1:1], 1'b1};
      else
        acc_next = shifted;
    end else begin
      sum      = acc[0] ? ({1'b0, acc[2*N-1:N]} + {1'b0, operand})
                        : {1'b0, acc[2*N-1:N]};
      acc_next = {1'b0, sum, acc[N-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MIPS multiply/divide unit with HI/LO registers.
// Define MDU_SIGNED_EN to make MULT/DIV (op[1]=1) signed two's complement.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  mdu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [N-1:0]     operand;
  logic [2*N:0]     acc, acc_next;
  logic [N-1:0]     mag_a, mag_b;
  logic [N-1:0]     res_hi, res_lo;

  mdu_step #(.N(N)) u_step (
    .acc      (acc),
    .operand  (operand),
    .op       (op_q),
    .acc_next (acc_next)
  );

`ifdef MDU_SIGNED_EN
  logic         neg_q, rsign_q, dz_q;
  logic         sa, sb;
  logic [2*N-1:0] prod;

  always_comb begin
    sa    = op[1] & inA[N-1];
    sb    = op[1] & inB[N-1];
    mag_a = sa ? -inA : inA;
    mag_b = sb ? -inB : inB;
  end

  // Divide-by-zero keeps the all-ones quotient; the remainder sign fix restores the dividend.
  always_comb begin
    prod   = neg_q ? -acc[2*N-1:0] : acc[2*N-1:0];
    res_hi = prod[2*N-1:N];
    res_lo = prod[N-1:0];
    if (mdu_is_div(op_q)) begin
      res_lo = (neg_q && !dz_q) ? -acc[N-1:0] : acc[N-1:0];
      res_hi = rsign_q ? -acc[2*N-1:N] : acc[2*N-1:N];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      neg_q   <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (state == MDU_IDLE && start) begin
      neg_q   <= sa ^ sb;
      rsign_q <= sa;
      dz_q    <= (inB == '0);
    end
  end
`else
  always_comb begin
    mag_a  = inA;
    mag_b  = inB;
    res_hi = acc[2*N-1:N];
    res_lo = acc[N-1:0];
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= MDU_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MDU_IDLE:   if (start) state_next = MDU_RUN;
      MDU_RUN:    if (cnt == '0) state_next = MDU_FINISH;
      MDU_FINISH: state_next = MDU_IDLE;
      default:    state_next = MDU_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != MDU_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      op_q    <= '0;
      operand <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_IDLE: begin
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
          if (start) begin
            op_q <= op;
            cnt  <= CNT_W'(N - 1);
            if (mdu_is_div(op)) begin
              operand <= mag_b;
              acc     <= {{(N+1){1'b0}}, mag_a};
            end else begin
              operand <= mag_a;
              acc     <= {{(N+1){1'b0}}, mag_b};
            end
          end
        end
        MDU_RUN: begin
          acc <= acc_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        MDU_FINISH: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, checked on done.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = '0;
  logic [31:0] inA   = '0;
  logic [31:0] inB   = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wd    = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   done_seen  = 0;

  mult_div_unit #(.N(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
      end
    end
  end

  // Caller sits at a negedge; returns at the negedge where done should be high.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    exp_t e;
    e.name = name; e.hi = eh; e.lo = el;
    sb_q.push_back(e);
    start = 1'b1; op = o; inA = a; inB = b;
    @(negedge clock);
    start = 1'b0; inA = $urandom; inB = $urandom; op = $urandom_range(0, 3);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'd33);
    chk({name, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int d0;
    int n;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_op("multu_max", MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu_100_7", MDU_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_5_0", MDU_OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("multu_shift", MDU_OP_MULTU, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780);
    run_op("divu_7_100", MDU_OP_DIVU, 32'd7, 32'd100, 32'd7, 32'd0);
    run_op("divu_max_1", MDU_OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF);
`ifdef MDU_SIGNED_EN
    run_op("mult_m3_5", MDU_OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_m7_2", MDU_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
`else
    run_op("mult_m3_5", MDU_OP_MULT, 32'hFFFFFFFD, 32'd5, 32'd4, 32'hFFFFFFF1);
    run_op("div_m7_2", MDU_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC);
    run_op("div_ovf", MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
`endif
    @(negedge clock);
    chk("done_single_pulse", {31'd0, done}, 32'd0);

    // MTHI / MTLO in IDLE
    hi_we = 1'b1; wd = 32'hDEAD;
    @(negedge clock);
    chk("mthi", hi, 32'hDEAD);
    hi_we = 1'b0; lo_we = 1'b1; wd = 32'hBEEF;
    @(negedge clock);
    chk("mtlo", lo, 32'hBEEF);
    chk("mtlo_hi_kept", hi, 32'hDEAD);
    lo_we = 1'b0;

    // MTHI/MTLO while busy are ignored
    start = 1'b1; op = MDU_OP_MULTU; inA = 32'd3; inB = 32'd4;
    sb_q.push_back('{name: "multu_3_4", hi: 32'd0, lo: 32'd12});
    @(negedge clock);
    start = 1'b0;
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234;
    repeat (3) @(negedge clock);
    chk("busy_mthi_hi", hi, 32'hDEAD);
    chk("busy_mtlo_lo", lo, 32'hBEEF);
    hi_we = 1'b0; lo_we = 1'b0;
    n = 0;
    while (!done && n < 100) begin n++; @(negedge clock); end
    chk("multu_3_4_timeout", {31'd0, done}, 32'd1);
    @(negedge clock);

    // MTHI with start in same IDLE cycle; result overwrites later
    hi_we = 1'b1; wd = 32'h55;
    start = 1'b1; op = MDU_OP_MULTU; inA = 32'd2; inB = 32'd3;
    sb_q.push_back('{name: "multu_2_3", hi: 32'd0, lo: 32'd6});
    @(negedge clock);
    hi_we = 1'b0; start = 1'b0;
    chk("mthi_with_start", hi, 32'h55);
    n = 0;
    while (!done && n < 100) begin n++; @(negedge clock); end
    chk("multu_2_3_timeout", {31'd0, done}, 32'd1);
    @(negedge clock);

    // Start while busy is ignored
    d0 = done_seen;
    start = 1'b1; op = MDU_OP_DIVU; inA = 32'd100; inB = 32'd7;
    sb_q.push_back('{name: "divu_ignore2", hi: 32'd2, lo: 32'd14});
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    start = 1'b1; op = MDU_OP_MULTU; inA = 32'd9; inB = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);
    chk("ignored_start_single_done", 32'(done_seen - d0), 32'd1);
    chk("ignored_start_idle", {31'd0, busy}, 32'd0);

    // Reset mid-operation discards the result
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h77;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    d0 = done_seen;
    start = 1'b1; op = MDU_OP_MULTU; inA = 32'd6; inB = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("midreset_no_done", 32'(done_seen - d0), 32'd0);
    chk("midreset_hi_after", hi, 32'd0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
